digital_lock: RTL and testbench
===============================

Name: digital_lock

Overview:
Three-step combination lock FSM. It samples a 3-bit code input on every rising clock edge and advances one state per correct code. After the third correct code it asserts an unlock output. It is a standalone control block whose current state is exported for status and debug.

Parameters:
W, 3, width of the code input x
CODE0, 3'b011, first code of the combination
CODE1, 3'b111, second code of the combination
CODE2, 3'b101, third code of the combination (unlock)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
x  input  W (3)  code input, sampled every rising edge of clk
y  output  1  unlock indicator; 1 only while the lock is open
state  output  2  current FSM state encoding

Interface:
- One clock (clk).
- Reset is synchronous and active-high (reset). It is sampled only on the rising edge of clk.

Behaviour:
- Moore FSM, single state register, 2-bit encoding:
  - S0 = 2'b00: locked or idle.
  - S1 = 2'b01: CODE0 accepted.
  - S2 = 2'b10: CODE0 then CODE1 accepted.
  - S3 = 2'b11: open.
- Reset: on a rising edge with reset=1, state <= S0 and y becomes 0. Reset has priority over x. Reset mid-sequence, including in S3, returns to S0 on that edge.
- Outputs:
  - state is driven directly from the register.
  - y = (state == S3), decoded combinationally from the register with no extra register stage.
  - y therefore rises in the same cycle state becomes 2'b11.
- Transitions, evaluated at each rising edge with reset=0. Exactly one rule applies, checked in the order listed.
  - S0:
    - x==CODE0 -> S1.
    - Else stay S0.
  - S1:
    - x==CODE1 -> S2.
    - x==CODE0 -> S1 (restart counts as the first code).
    - Else -> S0.
  - S2:
    - x==CODE2 -> S3.
    - x==CODE0 -> S1.
    - Else -> S0.
  - S3:
    - x==CODE2 -> stay S3 (hold open while the code is held).
    - x==CODE0 -> S1.
    - Else -> S0 (relock).
- Latency: each accepted code takes effect one edge after x is stable. The minimum unlock is 3 consecutive edges with CODE0, CODE1, CODE2. y asserts after the third edge.
- Holding one code across several edges does not advance the FSM more than one step:
  - S1 with CODE1 repeated: first edge -> S2, next edge (CODE1 != CODE2, != CODE0) -> S0.
  - Exception: CODE0 repeated in S1 stays S1.
- Parameter legality: CODE0, CODE1, CODE2 must be pairwise distinct. Behaviour with equal codes is undefined; elaboration may flag it.
- x is an unregistered synchronous input. No debouncing or synchronizer is included.
- No X or Z propagation: the illegal-state default goes to S0. All four encodings are legal, so the default is for completeness only.

Test Plan:
- Reset: reset=1 for one edge with x=3'b000 -> state=2'b00, y=0. Repeat with reset asserted while in S3 -> state=2'b00, y=0 on that edge.
- Idle rejection: from S0, apply x=001, 111, 101, 010 on successive edges -> state stays 2'b00, y=0 throughout.
- Unlock sequence: x=011, 111, 101 on three successive edges -> state 01, 10, 11. y=1 after the third edge. Then x=100 -> state=00, y=0.
- Hold-open: in S3 keep x=101 for 3 edges -> state=11, y=1 each cycle. Then x=011 -> state=01, y=0.
- Wrong mid-sequence: 011 then 000 -> S1 then S0. 011, 111, 110 -> S1, S2, S0. 011, 011, 111, 101 -> S1, S1, S2, S3.
- Reset priority: in S2 apply x=101 with reset=1 on the same edge -> state=00, y=0, not S3.

Source files
------------

// File: rtl/digital_lock.sv
// Three-step combination lock: CODE0, CODE1, CODE2 on successive edges opens it.
// y is decoded straight from the state register so it tracks the open state exactly.
module digital_lock #(
  parameter int           W     = 3,
  parameter logic [W-1:0] CODE0 = 3'b011,
  parameter logic [W-1:0] CODE1 = 3'b111,
  parameter logic [W-1:0] CODE2 = 3'b101
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x,
  output logic         y,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  state_e state_q;
  state_e state_d;

  // CODE0 always restarts the sequence at S1, from any state.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0: begin
        if (x == CODE0) state_d = S1;
        else            state_d = S0;
      end
      S1: begin
        if (x == CODE1)      state_d = S2;
        else if (x == CODE0) state_d = S1;
        else                 state_d = S0;
      end
      S2: begin
        if (x == CODE2)      state_d = S3;
        else if (x == CODE0) state_d = S1;
        else                 state_d = S0;
      end
      S3: begin
        if (x == CODE2)      state_d = S3;
        else if (x == CODE0) state_d = S1;
        else                 state_d = S0;
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  assign state = state_q;
  assign y     = (state_q == S3);

endmodule

// File: tb/tb_digital_lock.sv
// Scoreboard bench for digital_lock: each step pushes the expected {state, y}
// and the value is popped and compared one time unit after the clock edge.
module tb_digital_lock;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] x;
  logic       y;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  digital_lock dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one edge; expected y is 1 exactly when the expected state is 2'b11.
  task automatic apply(input logic r, input logic [2:0] xv, input logic [1:0] es);
    reset = r;
    x     = xv;
    exp_q.push_back({es, (es == 2'b11)});
    @(posedge clk);
    #1;
  endtask

  // Each step is {reset, x[2:0], expected_state[1:0]}.
  task automatic test_reset;
    logic [5:0] st [0:4];
    logic [2:0] e;
    st = '{{1'b1, 3'b000, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b101, 2'b11},
           {1'b1, 3'b101, 2'b00}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL reset[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_idle;
    logic [5:0] st [0:4];
    logic [2:0] e;
    st = '{{1'b1, 3'b000, 2'b00},
           {1'b0, 3'b001, 2'b00},
           {1'b0, 3'b111, 2'b00},
           {1'b0, 3'b101, 2'b00},
           {1'b0, 3'b010, 2'b00}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL idle[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_unlock;
    logic [5:0] st [0:3];
    logic [2:0] e;
    st = '{{1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b101, 2'b11},
           {1'b0, 3'b100, 2'b00}};
    for (int i = 0; i < 4; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL unlock[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_hold_open;
    logic [5:0] st [0:6];
    logic [2:0] e;
    st = '{{1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b101, 2'b11},
           {1'b0, 3'b101, 2'b11},
           {1'b0, 3'b101, 2'b11},
           {1'b0, 3'b101, 2'b11},
           {1'b0, 3'b011, 2'b01}};
    for (int i = 0; i < 7; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL hold_open[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_wrong_mid;
    logic [5:0] st [0:9];
    logic [2:0] e;
    st = '{{1'b1, 3'b000, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b000, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b110, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b101, 2'b11}};
    for (int i = 0; i < 10; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL wrong_mid[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  // Held CODE1 advances only once; CODE0 in S2 restarts at S1.
  task automatic test_back_to_back;
    logic [5:0] st [0:6];
    logic [2:0] e;
    st = '{{1'b1, 3'b000, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b111, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b0, 3'b011, 2'b01}};
    for (int i = 0; i < 7; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_priority;
    logic [5:0] st [0:4];
    logic [2:0] e;
    st = '{{1'b1, 3'b000, 2'b00},
           {1'b0, 3'b011, 2'b01},
           {1'b0, 3'b111, 2'b10},
           {1'b1, 3'b101, 2'b00},
           {1'b0, 3'b101, 2'b00}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i][5], st[i][4:2], st[i][1:0]);
      e = exp_q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        failures++;
        $display("FAIL reset_priority[%0d] got state=%b y=%b expected state=%b y=%b",
                 i, state, y, e[2:1], e[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    x     = 3'b000;
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_unlock();
    test_hold_open();
    test_wrong_mid();
    test_back_to_back();
    test_reset_priority();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
